// File: rtl/line_raster.sv
// ----------------------------------------------------------------------------
// line_raster -- Bresenham line rasteriser with a valid/ready pixel stream.
//
// Accepts one line request (p -> q) in IDLE, derives the Bresenham terms in
// SETUP, then emits one pixel per accepted handshake in EMIT, p first and
// q last. DONE pulses line_done for one cycle and returns to IDLE.
//
// Ports
//   clk, n_rst          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   line request handshake (in_ready only in IDLE)
//   p_x,p_y,q_x,q_y     signed start and end points (COORD_W bits)
//   pix_valid/pix_ready pixel stream handshake
//   pix_x, pix_y        presented pixel
//   pix_last            presented pixel is the end point q
//   line_done           one-cycle pulse as the line completes
//   pix_count           pixels accepted for the current / last line
//
// Build option
//   LINE_RASTER_CLIP_EN  pixels outside [0,SCREEN_W) x [0,SCREEN_H) are
//                        stepped over one per cycle and never presented.
// ----------------------------------------------------------------------------
module line_raster #(
    parameter int COORD_W  = 16,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] p_x,
    input  logic signed [COORD_W-1:0] p_y,
    input  logic signed [COORD_W-1:0] q_x,
    input  logic signed [COORD_W-1:0] q_y,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic signed [COORD_W-1:0] pix_x,
    output logic signed [COORD_W-1:0] pix_y,
    output logic                      pix_last,
    output logic                      line_done,
    output logic [COORD_W:0]          pix_count
);

    localparam int W2 = COORD_W + 2;

    if (COORD_W < 8 || COORD_W > 24) begin : g_bad_coord_w
        $error("line_raster: COORD_W must be in 8..24");
    end
    if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
        $error("line_raster: SCREEN_W and SCREEN_H must be positive");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EMIT, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d, qx_q, qx_d, qy_q, qy_d;
    logic signed [W2-1:0]      dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                      sx_q, sx_d, sy_q, sy_d;   // 1 = step negative
    logic [COORD_W:0]          cnt_q, cnt_d;

    function automatic logic signed [W2-1:0] ext(input logic signed [COORD_W-1:0] v);
        return {{2{v[COORD_W-1]}}, v};
    endfunction

    // Setup terms, computed from the registered endpoints
    logic signed [W2-1:0] ddx, ddy, adx, ady;
    assign ddx = ext(qx_q) - ext(x_q);
    assign ddy = ext(qy_q) - ext(y_q);
    assign adx = ddx[W2-1] ? -ddx : ddx;
    assign ady = ddy[W2-1] ? -ddy : ddy;

    // One Bresenham step; both tests use the pre-step error term.
    // e2 carries one extra bit so 2*err can never wrap.
    logic signed [W2:0]        e2, dx_e, dy_e;
    logic                      step_x, step_y;
    logic signed [W2-1:0]      add_x, add_y, err_nxt;
    logic signed [COORD_W-1:0] x_nxt, y_nxt;

    assign e2      = {err_q, 1'b0};
    assign dx_e    = {dx_q[W2-1], dx_q};
    assign dy_e    = {dy_q[W2-1], dy_q};
    assign step_x  = e2 > dy_e;
    assign step_y  = e2 < dx_e;
    assign add_x   = step_x ? dy_q : '0;
    assign add_y   = step_y ? dx_q : '0;
    assign err_nxt = err_q + add_x + add_y;
    assign x_nxt   = step_x ? (sx_q ? x_q - 1'b1 : x_q + 1'b1) : x_q;
    assign y_nxt   = step_y ? (sy_q ? y_q - 1'b1 : y_q + 1'b1) : y_q;

    logic at_q, in_view, hshake, advance;
    assign at_q = (x_q == qx_q) && (y_q == qy_q);

`ifdef LINE_RASTER_CLIP_EN
    assign in_view = (x_q >= 0) && (int'(x_q) < SCREEN_W) &&
                     (y_q >= 0) && (int'(y_q) < SCREEN_H);
`else
    assign in_view = 1'b1;
`endif

    // Clipped pixels advance without waiting for the consumer
    assign hshake  = pix_valid && pix_ready;
    assign advance = hshake || ((state_q == S_EMIT) && !in_view);

    assign in_ready  = (state_q == S_IDLE);
    assign pix_valid = (state_q == S_EMIT) && in_view;
    assign pix_last  = pix_valid && at_q;
    assign line_done = (state_q == S_DONE);
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_count = cnt_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = p_x;
                    y_d     = p_y;
                    qx_d    = q_x;
                    qy_d    = q_y;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_d    = adx;
                dy_d    = -ady;
                sx_d    = ddx[W2-1];
                sy_d    = ddy[W2-1];
                err_d   = adx - ady;
                cnt_d   = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (hshake) cnt_d = cnt_q + 1'b1;
                if (advance) begin
                    if (at_q) begin
                        state_d = S_DONE;
                    end else begin
                        x_d   = x_nxt;
                        y_d   = y_nxt;
                        err_d = err_nxt;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
